lsu_thread: RTL
===============

Name: lsu_thread

Overview:
- Per-thread load/store unit. Sits directly upstream of the memory controller, one instance per consumer slot (NUM_CONSUMERS = cores × threads).
- Turns a decoded LDR/STR into a single valid/ready transaction on the controller's consumer port.
- Returns load data to the thread's register file and reports its progress to the core scheduler.

Parameters:
ADDR_BITS, 8, memory address width; must match the controller
DATA_BITS, 8, data and register width
TIMEOUT_CYCLES, 255, maximum WAITING cycles before abort; 0 disables the timeout

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  thread active in the current block
core_state  input  3  core pipeline phase; 3'b011 = REQUEST, 3'b110 = UPDATE, other codes ignored
decoded_mem_read_enable  input  1  current instruction is LDR
decoded_mem_write_enable  input  1  current instruction is STR
rs  input  DATA_BITS  address operand
rt  input  DATA_BITS  store data operand
mem_read_valid  output  1  read request to controller
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  controller read acknowledge
mem_read_data  input  DATA_BITS  read data, valid while mem_read_ready=1
mem_write_valid  output  1  write request to controller
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_BITS  write data
mem_write_ready  input  1  controller write acknowledge
lsu_state  output  2  00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
lsu_out  output  DATA_BITS  last loaded value
lsu_error  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0 at a rising edge):
  - All outputs go to 0, lsu_state goes to IDLE, timeout counter clears.
  - Takes effect mid-transaction: a valid in flight drops at that edge; no completion occurs.
- Outputs: all registered; no combinational input-to-output paths.
- Address: rs[ADDR_BITS-1:0] if ADDR_BITS<=DATA_BITS, else rs zero-extended.
- IDLE:
  - If enable=1, core_state=REQUEST and (read_en or write_en): latch address, latch rt, latch op, go REQUESTING.
  - If both read_en and write_en are set, read wins and the write is dropped.
  - Otherwise hold IDLE.
- REQUESTING (exactly 1 cycle):
  - Assert mem_read_valid or mem_write_valid (per latched op) at the exiting edge.
  - Drive the latched address/data; go WAITING.
- WAITING:
  - valid, address and data held stable until the matching ready is sampled 1.
  - On that edge: valid<=0, go DONE. For reads, lsu_out<=mem_read_data on the same edge.
  - Only the matching ready is honoured; the opposite ready is ignored.
- Timeout:
  - Counter increments each WAITING cycle without ready.
  - When it reaches TIMEOUT_CYCLES: valid<=0, lsu_error<=1, go DONE, lsu_out unchanged.
  - Ready arriving on that same edge wins over timeout (normal completion, no error).
  - lsu_error clears only on reset.
- DONE: hold until core_state=UPDATE, then go IDLE on that edge. A new REQUEST cannot be accepted in the same cycle.
- enable deasserted mid-transaction: ignored; the transaction completes normally.
- ready sampled in IDLE, REQUESTING or DONE: ignored.
- Latency: request sampled at edge E0 → valid high after E1. If ready is high in the first WAITING cycle, DONE after E2 (minimum 3 cycles REQUEST to DONE).
- At most one outstanding transaction; never assert both valids.

Test Plan:
- Load: rs=0x2A, read_en=1, REQUEST; ready=1 with data 0x5C two cycles after valid rises → mem_read_address=0x2A held throughout; valid drops next edge; lsu_out=0x5C; DONE; UPDATE → IDLE.
- Store: rs=0x10, rt=0xF3, write_en=1; ready after 4 cycles → write_valid high exactly 5 cycles with addr 0x10 / data 0xF3; lsu_out unchanged; no read_valid.
- Both enables set with rs=0x07 → only mem_read_valid rises; mem_write_valid stays 0 throughout.
- TIMEOUT_CYCLES=4, ready never asserted → valid high 4 cycles then 0; lsu_error=1, stays 1 through subsequent transactions until reset.
- Reset=0 while WAITING with valid=1 → next edge all outputs 0, lsu_state=00; releasing reset with no request keeps the bus idle.
- Ignore cases: enable=0, or core_state≠REQUEST, or stray mem_read_ready=1 in IDLE → no valid, lsu_out unchanged, lsu_state stays 00.

Source files
------------

// File: rtl/lsu_thread.sv
// lsu_thread: per-thread load/store unit.
// Turns one decoded LDR/STR into a single valid/ready transaction on the
// memory controller consumer port. Load data is returned on lsu_out, and the
// scheduler follows progress through lsu_state. All outputs are registered.
module lsu_thread #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   // The counter only has to reach TIMEOUT_CYCLES-1; the abort happens on
   // the edge where it would step to TIMEOUT_CYCLES.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      REQUESTING = 2'b01,
      WAITING    = 2'b10,
      DONE       = 2'b11
   } state_t;

   state_t               state_reg,       state_next;
   logic                 op_read_reg,     op_read_next;
   logic [ADDR_BITS-1:0] addr_reg,        addr_next;
   logic [DATA_BITS-1:0] data_reg,        data_next;
   logic                 read_valid_reg,  read_valid_next;
   logic                 write_valid_reg, write_valid_next;
   logic [DATA_BITS-1:0] out_reg,         out_next;
   logic                 error_reg,       error_next;
   logic [CNT_W-1:0]     cnt_reg,         cnt_next;

   logic [ADDR_BITS-1:0] req_addr;
   logic                 ready_hit;

   // Address operand is truncated or zero-extended to the bus width.
   generate
      if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
         assign req_addr = rs[ADDR_BITS-1:0];
      end else begin : g_addr_ext
         assign req_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
      end
   endgenerate

   // Only the ready that matches the latched operation completes it.
   assign ready_hit = op_read_reg ? mem_read_ready : mem_write_ready;

   // State and output registers; reset drops any request in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= IDLE;
         op_read_reg     <= 1'b0;
         addr_reg        <= '0;
         data_reg        <= '0;
         read_valid_reg  <= 1'b0;
         write_valid_reg <= 1'b0;
         out_reg         <= '0;
         error_reg       <= 1'b0;
         cnt_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         op_read_reg     <= op_read_next;
         addr_reg        <= addr_next;
         data_reg        <= data_next;
         read_valid_reg  <= read_valid_next;
         write_valid_reg <= write_valid_next;
         out_reg         <= out_next;
         error_reg       <= error_next;
         cnt_reg         <= cnt_next;
      end
   end

   // Next-state and next-output logic for the single-transaction FSM.
   always_comb begin
      state_next       = state_reg;
      op_read_next     = op_read_reg;
      addr_next        = addr_reg;
      data_next        = data_reg;
      read_valid_next  = read_valid_reg;
      write_valid_next = write_valid_reg;
      out_next         = out_reg;
      error_next       = error_reg;
      cnt_next         = cnt_reg;

      case (state_reg)
         IDLE: begin
            if (enable && core_state == CORE_REQUEST &&
                (decoded_mem_read_enable || decoded_mem_write_enable)) begin
               addr_next    = req_addr;
               data_next    = rt;
               // A read wins when both enables are set.
               op_read_next = decoded_mem_read_enable;
               state_next   = REQUESTING;
            end
         end
         REQUESTING: begin
            read_valid_next  = op_read_reg;
            write_valid_next = !op_read_reg;
            cnt_next         = '0;
            state_next       = WAITING;
         end
         WAITING: begin
            if (ready_hit) begin
               read_valid_next  = 1'b0;
               write_valid_next = 1'b0;
               if (op_read_reg) begin
                  out_next = mem_read_data;
               end
               state_next = DONE;
            end else if (TIMEOUT_CYCLES != 0 && cnt_reg == CNT_LAST) begin
               read_valid_next  = 1'b0;
               write_valid_next = 1'b0;
               error_next       = 1'b1;
               state_next       = DONE;
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         DONE: begin
            if (core_state == CORE_UPDATE) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_read_valid    = read_valid_reg;
   assign mem_read_address  = addr_reg;
   assign mem_write_valid   = write_valid_reg;
   assign mem_write_address = addr_reg;
   assign mem_write_data    = data_reg;
   assign lsu_state         = state_reg;
   assign lsu_out           = out_reg;
   assign lsu_error         = error_reg;

endmodule
